alu_share_arbiter: RTL and testbench

// Shares one registered ALU between two requesters: port 0 is the pipeline EX path and

---
 rtl/alu_share_arbiter.sv | 114 +++++++++++
 tb/tb_alu_share_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one registered ALU between the EX path (port 0)
// and the auxiliary address/branch-target calculator (port 1).
module alu_share_arbiter #(
    parameter int         WIDTH              = 32,
    parameter int         SHAMT_W            = 5,
    parameter logic [3:0] ALU_OP_ADD         = 4'd0,
    parameter logic [3:0] ALU_OP_SUB         = 4'd1,
    parameter logic [3:0] ALU_OP_AND         = 4'd2,
    parameter logic [3:0] ALU_OP_OR          = 4'd3,
    parameter logic [3:0] ALU_OP_XOR         = 4'd4,
    parameter logic [3:0] ALU_OP_LT          = 4'd5,
    parameter logic [3:0] ALU_OP_NONE        = 4'd6,
    parameter logic [3:0] ALU_OP_SHIFT_LEFT  = 4'd7,
    parameter logic [3:0] ALU_OP_SHIFT_RIGHT = 4'd8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req_a_0,
    input  logic [WIDTH-1:0] req_b_0,
    input  logic [3:0]       req_op_0,
    input  logic [WIDTH-1:0] req_a_1,
    input  logic [WIDTH-1:0] req_b_1,
    input  logic [3:0]       req_op_1,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             busy,
    output logic             grant_id
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RESP = 1'b1;

    logic [0:0]       state;
    logic             rr_ptr;
    logic             grant;
    logic             grant_valid;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [3:0]       sel_op;
    logic [WIDTH-1:0] alu_out;

    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    always_comb begin
        grant_valid = 1'b0;
        grant       = 1'b0;
        req_ready   = 2'b00;
        if (state == IDLE) begin
            unique case (req_valid)
                2'b01:   begin grant_valid = 1'b1; grant = 1'b0;   end
                2'b10:   begin grant_valid = 1'b1; grant = 1'b1;   end
                2'b11:   begin grant_valid = 1'b1; grant = rr_ptr; end
                default: begin grant_valid = 1'b0; grant = 1'b0;   end
            endcase
            req_ready[grant] = grant_valid;
        end
    end

    assign sel_a  = grant ? req_a_1  : req_a_0;
    assign sel_b  = grant ? req_b_1  : req_b_0;
    assign sel_op = grant ? req_op_1 : req_op_0;

    // LT flag is inverted (0 when a<b) to match the EX-stage encoding.
    always_comb begin
        alu_out = '0;
        case (sel_op)
            ALU_OP_ADD:         alu_out = sel_a + sel_b;
            ALU_OP_SUB:         alu_out = sel_a - sel_b;
            ALU_OP_AND:         alu_out = sel_a & sel_b;
            ALU_OP_OR:          alu_out = sel_a | sel_b;
            ALU_OP_XOR:         alu_out = sel_a ^ sel_b;
            ALU_OP_LT:          alu_out = ($signed(sel_a) < $signed(sel_b)) ? '0 : WIDTH'(1);
            ALU_OP_NONE:        alu_out = '0;
            ALU_OP_SHIFT_LEFT:  alu_out = sel_a << sel_b[SHAMT_W-1:0];
            ALU_OP_SHIFT_RIGHT: alu_out = sel_a >> sel_b[SHAMT_W-1:0];
            default:            alu_out = '0;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            rsp_result <= '0;
            grant_id   <= 1'b0;
            rr_ptr     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        rsp_result <= alu_out;
                        grant_id   <= grant;
                        rr_ptr     <= ~grant;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready[grant_id]) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rsp_valid = (state == RESP) ? (grant_id ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_zero  = (rsp_result == '0);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed cases plus a randomized
// fairness soak checked against a behavioural arbitration/ALU model.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req_a_0, req_b_0, req_a_1, req_b_1;
    logic [3:0]  req_op_0, req_op_1;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_zero;
    logic        busy;
    logic        grant_id;

    int n_checks = 0;
    int n_errors = 0;
    int prio     = 0;   // model: requester favoured at the next tie
    int last_g   = 0;

    always #5 clk = ~clk;

    alu_share_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a_0   (req_a_0),
        .req_b_0   (req_b_0),
        .req_op_0  (req_op_0),
        .req_a_1   (req_a_1),
        .req_b_1   (req_b_1),
        .req_op_1  (req_op_1),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_result(rsp_result),
        .rsp_zero  (rsp_zero),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input int op);
        int sh;
        sh = int'(b % 32);
        case (op)
            0:       return a + b;
            1:       return a - b;
            2:       return a & b;
            3:       return a | b;
            4:       return a ^ b;
            5:       return ($signed(a) < $signed(b)) ? 32'd0 : 32'd1;
            7:       return a << sh;
            8:       return a >> sh;
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents mask v, checks the grant, then the response one edge later.
    task automatic serve(input logic [1:0] v, input string tag);
        int          g;
        logic [31:0] exp;
        g   = (v == 2'b11) ? prio : int'(v[1]);
        exp = (g == 1) ? alu_model(req_a_1, req_b_1, int'(req_op_1))
                       : alu_model(req_a_0, req_b_0, int'(req_op_0));
        req_valid = v;
        #1;
        check({tag, " req_ready"}, 32'(req_ready), 32'(2'b01 << g));
        tick();
        req_valid[g] = 1'b0;
        #1;
        check({tag, " rsp_valid"}, 32'(rsp_valid), 32'(2'b01 << g));
        check({tag, " result"},    rsp_result, exp);
        check({tag, " zero"},      32'(rsp_zero), 32'(exp == 32'd0));
        check({tag, " grant_id"},  32'(grant_id), 32'(g));
        check({tag, " busy"},      32'(busy), 32'd1);
        check({tag, " no ready while busy"}, 32'(req_ready), 32'd0);
        prio   = 1 - g;
        last_g = g;
    endtask

    task automatic complete(input string tag);
        rsp_ready = 2'b01 << last_g;
        tick();
        rsp_ready = 2'b00;
        check({tag, " idle after accept"}, {31'd0, busy}, 32'd0);
        check({tag, " rsp_valid cleared"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        {req_a_0, req_b_0, req_a_1, req_b_1} = '0;
        req_op_0 = 4'd0;
        req_op_1 = 4'd0;
        tick();
        tick();
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset req_ready", 32'(req_ready), 32'd0);
        check("reset result",    rsp_result, 32'd0);
        check("reset zero",      32'(rsp_zero), 32'd1);
        check("reset busy",      32'(busy), 32'd0);
        check("reset grant_id",  32'(grant_id), 32'd0);
        reset = 1'b0;
        tick();
        check("idle no request ready", 32'(req_ready), 32'd0);

        // Contention: requester 0 wins the first tie, requester 1 the next.
        req_a_0 = 32'd9;  req_b_0 = 32'd9; req_op_0 = 4'd1;
        req_a_1 = -32'sd3; req_b_1 = 32'd2; req_op_1 = 4'd5;
        serve(2'b11, "contend sub");
        complete("contend sub");
        req_a_0 = 32'd5; req_b_0 = 32'd7; req_op_0 = 4'd0;
        serve(2'b11, "contend lt");
        complete("contend lt");

        // Single add, held for 3 cycles; non-owner rsp_ready ignored.
        serve(2'b01, "single add");
        rsp_ready = 2'b10;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold result", rsp_result, 32'd12);
            check("hold valid",  32'(rsp_valid), 32'd1);
        end
        rsp_ready = 2'b00;
        complete("single add");

        // Shifts use only the low 5 bits of b.
        req_a_1 = 32'h8000_0001; req_b_1 = 32'h0000_0021; req_op_1 = 4'd8;
        serve(2'b10, "shift right");
        check("shift right value", rsp_result, 32'h4000_0000);
        complete("shift right");
        req_op_1 = 4'd7;
        serve(2'b10, "shift left");
        check("shift left value", rsp_result, 32'h0000_0002);
        complete("shift left");

        // Wraparound and unknown opcode.
        req_a_0 = 32'hffff_ffff; req_b_0 = 32'd1; req_op_0 = 4'd0;
        serve(2'b01, "wrap add");
        complete("wrap add");
        req_a_1 = 32'h1234_5678; req_b_1 = 32'h0000_0011; req_op_1 = 4'd12;
        serve(2'b10, "illegal op");
        complete("illegal op");

        // Reset while in RESP drops the response in the same cycle.
        req_a_1 = 32'd1; req_b_1 = 32'd1; req_op_1 = 4'd0;
        serve(2'b10, "pre reset");
        reset = 1'b1;
        #1;
        check("async reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("async reset result",    rsp_result, 32'd0);
        check("async reset zero",      32'(rsp_zero), 32'd1);
        check("async reset busy",      32'(busy), 32'd0);
        tick();
        reset = 1'b0;
        prio  = 0;
        tick();

        // Fairness soak with random operations; only the served side takes new operands.
        req_a_0 = $urandom; req_b_0 = $urandom; req_op_0 = 4'($urandom_range(0, 15));
        req_a_1 = $urandom; req_b_1 = $urandom; req_op_1 = 4'($urandom_range(0, 15));
        for (int i = 0; i < 20; i++) begin
            int prev_g;
            prev_g = last_g;
            serve(2'b11, "soak");
            if (i > 0) check("soak alternation", 32'(last_g), 32'(1 - prev_g));
            if (last_g == 0) begin
                req_a_0 = $urandom; req_b_0 = $urandom; req_op_0 = 4'($urandom_range(0, 15));
            end else begin
                req_a_1 = $urandom; req_b_1 = $urandom; req_op_1 = 4'($urandom_range(0, 15));
            end
            complete("soak");
        end
        req_valid = 2'b00;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
